block_scheduler: RTL and testbench

//   Parametrised successor to the block distributor. Takes one block stream and spreads it over
//   NUM_LANES crypto lanes. Each block is tagged with a wrapping sequence ID, and each lane has its
//   own FIFO so a slow lane does not stall the others. Two run-time modes: strict round-robin and

---
 rtl/block_sched_pkg.sv | 16 +
 rtl/block_scheduler_if.sv | 27 ++
 rtl/block_sched_lane_fifo.sv | 55 +++++
 rtl/block_scheduler.sv | 148 ++++++++++++++
 tb/tb_block_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_sched_pkg.sv
// Shared types and helpers for the block scheduler.
// The BLOCK_SCHED_STATS_EN macro (see block_scheduler.sv) adds statistics outputs.
package block_sched_pkg;

  typedef enum logic {
    SCHED_STRICT_RR    = 1'b0,
    SCHED_SKIP_FULL_RR = 1'b1
  } sched_mode_e;

  localparam int STAT_WIDTH = 32;

  function automatic int unsigned next_lane(input int unsigned cur, input int unsigned num_lanes);
    return (cur + 1 >= num_lanes) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/block_scheduler_if.sv
// Block input stream and per-lane output streams of the block scheduler.
interface block_scheduler_if #(
  parameter int BLOCK_WIDTH = 32,
  parameter int NUM_LANES   = 4,
  parameter int SEQ_W       = 8
);
  logic [BLOCK_WIDTH-1:0]                data_in;
  logic                                  data_in_valid;
  logic                                  data_in_ready;
  logic [NUM_LANES-1:0][BLOCK_WIDTH-1:0] lane_data;
  logic [NUM_LANES-1:0][SEQ_W-1:0]       lane_seq_id;
  logic [NUM_LANES-1:0]                  lane_valid;
  logic [NUM_LANES-1:0]                  lane_ready;
  logic [NUM_LANES-1:0]                  lane_full;

  // A transfer happens on a rising edge where valid && ready; a held valid keeps its payload
  // stable until that edge, and ready never depends combinationally on valid.
  modport master (
    output data_in, data_in_valid, lane_ready,
    input  data_in_ready, lane_data, lane_seq_id, lane_valid, lane_full
  );

  modport slave (
    input  data_in, data_in_valid, lane_ready,
    output data_in_ready, lane_data, lane_seq_id, lane_valid, lane_full
  );
endinterface

// File: rtl/block_sched_lane_fifo.sv
// First-word-fall-through FIFO for one scheduler lane; head entry is visible on dout.
module block_sched_lane_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/block_scheduler.sv
// Spreads one tagged block stream over NUM_LANES lane FIFOs in strict or skip-full round-robin.
// Defining BLOCK_SCHED_STATS_EN adds per-lane dispatch and input stall counters.
module block_scheduler
  import block_sched_pkg::*;
#(
  parameter int BLOCK_WIDTH       = 32,
  parameter int NUM_LANES         = 4,
  parameter int SEQUENCE_ID_WIDTH = 8,
  parameter int LANE_FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_mode,
  input  logic              flush,
  block_scheduler_if.slave  bus,
  output logic              idle
`ifdef BLOCK_SCHED_STATS_EN
  ,
  output logic [NUM_LANES-1:0][STAT_WIDTH-1:0] stat_dispatched,
  output logic [STAT_WIDTH-1:0]                stat_stall
`endif
);
  localparam int SEQ_W   = SEQUENCE_ID_WIDTH;
  localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int ENTRY_W = SEQ_W + BLOCK_WIDTH;

  logic [LANE_W-1:0]               ptr_q, ptr_d, target;
  logic [SEQ_W-1:0]                seq_q, seq_d;
  logic [NUM_LANES-1:0]            full, empty, push, pop;
  logic [NUM_LANES-1:0][ENTRY_W-1:0] head;
  logic                            found, accept;
  sched_mode_e                     mode;

  // Target lane selection uses only registered FIFO state, so a same-cycle pop never frees a slot.
  always_comb begin : target_sel
    logic [LANE_W-1:0] cand;
    mode   = sched_mode_e'(sched_mode);
    target = ptr_q;
    found  = 1'b0;
    cand   = ptr_q;
    if (mode == SCHED_SKIP_FULL_RR) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        cand = LANE_W'((32'(ptr_q) + 32'(k)) % NUM_LANES);
        if (!found && !full[cand]) begin
          found  = 1'b1;
          target = cand;
        end
      end
    end else begin
      found = !full[ptr_q];
    end
  end

  assign bus.data_in_ready = rst_n && !flush && found;
  assign accept            = bus.data_in_valid && bus.data_in_ready;
  assign pop               = bus.lane_ready & ~empty & {NUM_LANES{~flush}};

  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (accept && (target == LANE_W'(i))) push[i] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    seq_d = seq_q;
    if (flush) begin
      ptr_d = '0;
      seq_d = '0;
    end else if (accept) begin
      ptr_d = LANE_W'(next_lane(32'(target), NUM_LANES));
      seq_d = seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      seq_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      seq_q <= seq_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    block_sched_lane_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (LANE_FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push[g]),
      .din   ({seq_q, bus.data_in}),
      .pop   (pop[g]),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      bus.lane_data[i]   = head[i][BLOCK_WIDTH-1:0];
      bus.lane_seq_id[i] = head[i][ENTRY_W-1:BLOCK_WIDTH];
    end
  end

  assign bus.lane_valid = ~empty;
  assign bus.lane_full  = full;
  assign idle           = &empty;

`ifdef BLOCK_SCHED_STATS_EN
  logic [NUM_LANES-1:0][STAT_WIDTH-1:0] disp_q, disp_d;
  logic [STAT_WIDTH-1:0]                stall_q, stall_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    disp_d  = disp_q;
    stall_d = stall_q;
    if (flush) begin
      disp_d  = '0;
      stall_d = '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (push[i] && (disp_q[i] != '1)) disp_d[i] = disp_q[i] + 1'b1;
      end
      if (bus.data_in_valid && !bus.data_in_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q  <= '0;
      stall_q <= '0;
    end else begin
      disp_q  <= disp_d;
      stall_q <= stall_d;
    end
  end

  assign stat_dispatched = disp_q;
  assign stat_stall      = stall_q;
`endif

endmodule

// File: tb/tb_block_scheduler.sv
// Self-checking bench for block_scheduler: vector table, directed corner sequences, random traffic.
module tb_block_scheduler;
  localparam int BW = 32;
  localparam int NL = 4;
  localparam int SW = 8;
  localparam int DEPTH = 4;
  localparam int EW = SW + BW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sched_mode = 1'b0;
  logic flush = 1'b0;
  logic idle;

  always #5 clk = ~clk;

  block_scheduler_if #(.BLOCK_WIDTH(BW), .NUM_LANES(NL), .SEQ_W(SW)) bus ();

`ifdef BLOCK_SCHED_STATS_EN
  logic [NL-1:0][31:0] stat_dispatched;
  logic [31:0]         stat_stall;
`endif

  block_scheduler #(
    .BLOCK_WIDTH(BW), .NUM_LANES(NL), .SEQUENCE_ID_WIDTH(SW), .LANE_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sched_mode (sched_mode),
    .flush      (flush),
    .bus        (bus),
    .idle       (idle)
`ifdef BLOCK_SCHED_STATS_EN
    ,
    .stat_dispatched (stat_dispatched),
    .stat_stall      (stat_stall)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0] exp_q[NL][$];
  int ptr_m;
  int cnt_m;
  bit last_acc;
  int total = 0;
  int bad = 0;
`ifdef BLOCK_SCHED_STATS_EN
  longint disp_m[NL];
  longint stall_m;
`endif

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) exp_q[i].delete();
    ptr_m = 0;
    cnt_m = 0;
`ifdef BLOCK_SCHED_STATS_EN
    for (int i = 0; i < NL; i++) disp_m[i] = 0;
    stall_m = 0;
`endif
  endtask

  // Lane that would receive the presented block, or -1 if none can take it.
  function automatic int m_target();
    if (sched_mode == 1'b0) return (exp_q[ptr_m].size() < DEPTH) ? ptr_m : -1;
    for (int k = 0; k < NL; k++) begin
      if (exp_q[(ptr_m + k) % NL].size() < DEPTH) return (ptr_m + k) % NL;
    end
    return -1;
  endfunction

  function automatic bit m_ready();
    if (!rst_n || flush) return 1'b0;
    return m_target() >= 0;
  endfunction

  // Compare all outputs against the model, then advance the model over the coming edge.
  task automatic check_and_advance();
    bit rdy;
    int t;
    logic [NL-1:0] lv, lf;
    if (!rst_n) model_clear();
    rdy = m_ready();
    for (int i = 0; i < NL; i++) begin
      lv[i] = exp_q[i].size() > 0;
      lf[i] = exp_q[i].size() == DEPTH;
    end
    chk("data_in_ready", 64'(bus.data_in_ready), 64'(rdy));
    chk("lane_valid", 64'(bus.lane_valid), 64'(lv));
    chk("lane_full", 64'(bus.lane_full), 64'(lf));
    chk("idle", 64'(idle), 64'(lv == '0));
    for (int i = 0; i < NL; i++) begin
      if (lv[i]) chk($sformatf("lane%0d_head", i), 64'({bus.lane_seq_id[i], bus.lane_data[i]}), 64'(exp_q[i][0]));
    end
`ifdef BLOCK_SCHED_STATS_EN
    for (int i = 0; i < NL; i++) chk($sformatf("stat_disp%0d", i), 64'(stat_dispatched[i]), 64'(disp_m[i]));
    chk("stat_stall", 64'(stat_stall), 64'(stall_m));
`endif
    last_acc = 1'b0;
    if (rst_n && flush) begin
      model_clear();
    end else if (rst_n) begin
`ifdef BLOCK_SCHED_STATS_EN
      if (bus.data_in_valid && !rdy && stall_m < 64'hFFFF_FFFF) stall_m++;
`endif
      for (int i = 0; i < NL; i++) begin
        if (lv[i] && bus.lane_ready[i]) void'(exp_q[i].pop_front());
      end
      if (bus.data_in_valid && rdy) begin
        t = m_target();
        exp_q[t].push_back({SW'(cnt_m), bus.data_in});
`ifdef BLOCK_SCHED_STATS_EN
        if (disp_m[t] < 64'hFFFF_FFFF) disp_m[t]++;
`endif
        ptr_m = (t + 1) % NL;
        cnt_m = (cnt_m + 1) % (1 << SW);
        last_acc = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    #1;
    check_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] d, output int waited);
    bus.data_in = d;
    bus.data_in_valid = 1'b1;
    for (waited = 0; waited < 64; waited++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) chk("send_timeout", 64'(waited), 64'(0));
  endtask

  task automatic do_flush();
    bus.data_in_valid = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic check_landed(input string nm, input int lane, input logic [BW-1:0] d, input logic [SW-1:0] s);
    chk({nm, "_valid"}, 64'(bus.lane_valid[lane]), 64'(1));
    chk({nm, "_head"}, 64'({bus.lane_seq_id[lane], bus.lane_data[lane]}), 64'({s, d}));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          flush;
    logic          mode;
    logic          valid;
    logic [NL-1:0] lane_ready;
    logic          exp_ready;
    logic [NL-1:0] exp_lv;
  } vec_t;

  vec_t vt[10];

  initial begin
    int w;
    int wsum;

    vt[0] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000};
    vt[1] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001};
    vt[2] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0011};
    vt[3] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0111};
    vt[4] = '{1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b1111};
    vt[5] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1110};
    vt[6] = '{1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b1110};
    vt[7] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000};
    vt[8] = '{1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000};
    vt[9] = '{1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001};

    // ---- reset ----
    bus.data_in = '0;
    bus.data_in_valid = 1'b1;
    bus.lane_ready = '0;
    model_clear();
    #1;
    chk("reset_ready", 64'(bus.data_in_ready), 64'(0));
    chk("reset_idle", 64'(idle), 64'(1));
    chk("reset_lane_valid", 64'(bus.lane_valid), 64'(0));
    chk("reset_lane_full", 64'(bus.lane_full), 64'(0));
    repeat (3) cycle();
    bus.data_in_valid = 1'b0;
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 10; i++) begin
      flush = vt[i].flush;
      sched_mode = vt[i].mode;
      bus.data_in_valid = vt[i].valid;
      bus.data_in = 32'hA0 + 32'(i);
      bus.lane_ready = vt[i].lane_ready;
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(bus.data_in_ready), 64'(vt[i].exp_ready));
      chk($sformatf("vec%0d_lane_valid", i), 64'(bus.lane_valid), 64'(vt[i].exp_lv));
      cycle();
    end
    flush = 1'b0;

    // ---- async reset mid-stream ----
    sched_mode = 1'b0;
    bus.lane_ready = '0;
    for (int i = 0; i < 6; i++) send(32'h100 + 32'(i), w);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_lane_valid", 64'(bus.lane_valid), 64'(0));
    chk("t1_rst_idle", 64'(idle), 64'(1));
    chk("t1_rst_ready", 64'(bus.data_in_ready), 64'(0));
    cycle();
    rst_n = 1'b1;
    #1;
    chk("t1_release_ready", 64'(bus.data_in_ready), 64'(1));
    send(32'h1111, w);
    check_landed("t1_first", 0, 32'h1111, 8'd0);

    // ---- strict RR, all lanes ready, back-to-back ----
    do_flush();
    sched_mode = 1'b0;
    bus.lane_ready = '1;
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send(32'(i), w);
      wsum += w;
      check_landed($sformatf("t2_blk%0d", i), i % NL, 32'(i), SW'(i));
    end
    chk("t2_stall_cycles", 64'(wsum), 64'(0));
    bus.data_in_valid = 1'b0;
    cycle();

    // ---- strict RR with lane 1 blocked ----
    do_flush();
    sched_mode = 1'b0;
    bus.lane_ready = 4'b1101;
    wsum = 0;
    for (int i = 0; i < 17; i++) begin
      send(32'(i), w);
      wsum += w;
    end
    chk("t3_early_stalls", 64'(wsum), 64'(0));
    bus.data_in = 32'd17;
    bus.data_in_valid = 1'b1;
    chk("t3_stall_ready", 64'(bus.data_in_ready), 64'(0));
    chk("t3_lane1_full", 64'(bus.lane_full[1]), 64'(1));
    chk("t3_lane1_head", 64'({bus.lane_seq_id[1], bus.lane_data[1]}), 64'({8'd1, 32'd1}));
    repeat (3) cycle();
    chk("t3_still_stalled", 64'(bus.data_in_ready), 64'(0));
    bus.lane_ready = 4'b1111;
    chk("t3_pop_cycle_ready", 64'(bus.data_in_ready), 64'(0));
    cycle();
    chk("t3_after_pop_ready", 64'(bus.data_in_ready), 64'(1));
    cycle();
    send(32'd18, w);
    send(32'd19, w);
    bus.data_in_valid = 1'b0;
    cycle();

    // ---- skip-full RR with lane 1 blocked ----
    do_flush();
    sched_mode = 1'b1;
    bus.lane_ready = 4'b1101;
    wsum = 0;
    for (int i = 0; i < 17; i++) begin
      send(32'(i), w);
      wsum += w;
    end
    send(32'd17, w);
    wsum += w;
    check_landed("t4_blk17", 2, 32'd17, 8'd17);
    send(32'd18, w);
    wsum += w;
    send(32'd19, w);
    wsum += w;
    chk("t4_stall_cycles", 64'(wsum), 64'(0));
`ifdef BLOCK_SCHED_STATS_EN
    #1;
    chk("t4_stat_disp1", 64'(stat_dispatched[1]), 64'(4));
    chk("t4_stat_stall", 64'(stat_stall), 64'(0));
`endif
    bus.data_in_valid = 1'b0;
    cycle();

    // ---- sequence counter wrap ----
    do_flush();
    sched_mode = 1'b0;
    bus.lane_ready = '1;
    for (int i = 0; i < 300; i++) begin
      send(32'(i), w);
      if (i == 255) check_landed("t5_blk255", 3, 32'd255, 8'd255);
      if (i == 256) check_landed("t5_blk256", 0, 32'd256, 8'd0);
    end
    bus.data_in_valid = 1'b0;
    cycle();

    // ---- flush with full lanes and valid input ----
    do_flush();
    sched_mode = 1'b0;
    bus.lane_ready = '0;
    for (int i = 0; i < 15; i++) send(32'h600 + 32'(i), w);
    bus.data_in = 32'hDEAD;
    bus.data_in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("t6_flush_ready", 64'(bus.data_in_ready), 64'(0));
    cycle();
    flush = 1'b0;
    bus.data_in_valid = 1'b0;
    #1;
    chk("t6_post_lane_valid", 64'(bus.lane_valid), 64'(0));
    chk("t6_post_idle", 64'(idle), 64'(1));
    send(32'h600D, w);
    check_landed("t6_first", 0, 32'h600D, 8'd0);

    // ---- randomized traffic ----
    for (int c = 0; c < 800; c++) begin
      sched_mode = ($urandom_range(0, 9) < 2) ? ~sched_mode : sched_mode;
      bus.data_in_valid = ($urandom_range(0, 3) != 0);
      bus.data_in = $urandom;
      bus.lane_ready = NL'($urandom_range(0, (1 << NL) - 1));
      flush = ($urandom_range(0, 59) == 0);
      cycle();
    end
    flush = 1'b0;
    bus.data_in_valid = 1'b0;
    bus.lane_ready = '1;
    repeat (DEPTH + 2) cycle();
    chk("final_idle", 64'(idle), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
